fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipelined core; sits directly upstream of the main decoder.
- Holds the PC, runs a request/ready handshake with instruction memory and loads the IF/ID register.
- Supplies the decoder with the instruction word, whose bits [31:21] are the 11-bit opcode field.
- Accepts a branch redirect from the execute stage and a stall from the decode stage.

Parameters:
- N, 64, PC/address width.
- RESET_PC, 64'h0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  N  fetch address, equal to the PC.
- imem_ready  in  1  instruction memory returns imem_rdata this cycle.
- imem_rdata  in  32  returned instruction word.
- stall_d  in  1  decode stage cannot accept a new instruction.
- branch_taken  in  1  redirect request (PCSrc).
- branch_target  in  N  redirect address.
- instr_d  out  32  IF/ID instruction (opcode = instr_d[31:21]).
- pc_d  out  N  IF/ID PC of instr_d.
- valid_d  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset outputs: pc = RESET_PC; state = S_IDLE; imem_req = 0; instr_d = 0; pc_d = 0; valid_d = 0.
- Reset mid-transaction abandons the request; any later imem_ready is ignored while in S_IDLE.
- imem_addr = pc at all times.
- While imem_req = 1, pc must not change except through a redirect, which moves the FSM to S_DROP.
- FSM states:
  - S_IDLE: imem_req = 0. Next state is S_FETCH one cycle after reset is released.
  - S_FETCH: imem_req = 1.
    - imem_ready = 1 and the IF/ID slot is free (valid_d = 0 or stall_d = 0): capture instr_d <= imem_rdata, pc_d <= pc, valid_d <= 1, pc <= pc + 4. Stay in S_FETCH. This sustains 1 instruction/cycle with zero-wait memory.
    - imem_ready = 1 and the slot is not free: not allowed, because req is only raised when the slot is free or frees this cycle.
  - S_HOLD: entered from S_FETCH when valid_d = 1 and stall_d = 1 before imem_ready arrives. imem_req = 0. Return to S_FETCH when stall_d = 0.
  - S_DROP: entered on a redirect while a request is outstanding (S_FETCH and imem_ready = 0). imem_req = 1 with the old address held. On imem_ready, discard imem_rdata and go to S_FETCH with the new pc.
- A slot is consumed when valid_d = 1 and stall_d = 0.
- If the slot is consumed and nothing is captured, valid_d <= 0.
- If the slot is stalled, instr_d, pc_d and valid_d hold.
- Redirect (branch_taken = 1) has the highest priority over capture and stall:
  - pc <= {branch_target[N-1:2], 2'b00};
  - valid_d <= 0 (flush IF/ID), including when stall_d = 1;
  - a word returning in the same cycle is discarded.
- PC arithmetic is modulo 2^N; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Latency: imem_ready in cycle t gives valid_d in cycle t+1.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - adds outputs perf_fetched (32-bit) and perf_stall (32-bit), both reset to 0;
  - perf_fetched increments on each capture into IF/ID;
  - perf_stall increments each cycle with valid_d = 1 and stall_d = 1;
  - both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - typedef fetch_state_t {S_IDLE, S_FETCH, S_HOLD, S_DROP};
  - constant INSTR_W = 32;
  - constant PC_INC = 4;
  - localparams OPC_MSB = 31, OPC_LSB = 21 (used by the decoder hookup).
- One natural sub-module: if_id_reg, holding the IF/ID register with load, hold, flush and valid.

Test Plan:
- Reset, then zero-wait memory returning 0xF8400000, 0xF8000000, 0x8B000000 → valid_d = 1 from cycle 2; pc_d = 0, 4, 8 on consecutive cycles; instr_d[31:21] = 11'h7C2, then 11'h7C0.
- stall_d held high 3 cycles with valid_d = 1 → instr_d and pc_d frozen; imem_req = 0 during S_HOLD; fetch resumes at pc = pc_d + 4 after release.
- Memory with 2-cycle wait, branch_taken = 1 and branch_target = 0x103 issued mid-wait → late word discarded; next request at imem_addr = 0x100; valid_d = 0 until that word returns.
- branch_taken coinciding with imem_ready and stall_d = 1 → valid_d = 0 next cycle; pc = target.
- reset asserted during a pending request → all outputs return to reset values next cycle; subsequent stray imem_ready causes no capture.
- FETCH_PERF_EN defined: 5 fetches and 2 stall cycles → perf_fetched = 5, perf_stall = 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 pipeline front end.
package cpu_pkg;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} fetch_state_t;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INC  = 4;
   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 21;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

   // Opcode field as seen by the main decoder.
   function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold on stall, flush on redirect, drain when consumed.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter int unsigned N = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [N-1:0]       pc_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [N-1:0]       pc_o,
   output logic               valid_o
);

   logic [INSTR_W-1:0] instr_q;
   logic [N-1:0]       pc_q;
   logic               valid_q;

   // Flush wins over load; an unstalled live entry is consumed by decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
         valid_q <= 1'b1;
      end else if (valid_q && !stall_i) begin
         valid_q <= 1'b0;
      end
   end

   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC, imem request/ready handshake, IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int unsigned N        = 64,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [N-1:0]       imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall_d,
   input  logic               branch_taken,
   input  logic [N-1:0]       branch_target,
   output logic [INSTR_W-1:0] instr_d,
   output logic [N-1:0]       pc_d,
   output logic               valid_d
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);

   fetch_state_t state_q;
   logic         req_q;
   logic [N-1:0] pc_q;
   logic [N-1:0] tgt_q;

   logic         slot_free;
   logic         capture;
   logic [N-1:0] tgt_aligned;
   logic [N-1:0] pc_inc;

   assign slot_free   = !valid_d || !stall_d;
   assign capture     = (state_q == S_FETCH) && imem_ready && slot_free && !branch_taken;
   assign tgt_aligned = branch_target & ~N'(3);
   assign pc_inc      = pc_q + N'(PC_INC);

   // A redirect during an outstanding request keeps the old address on the
   // bus (S_DROP) and parks the target in tgt_q until the stale word returns.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
               if (branch_taken) pc_q <= tgt_aligned;
            end
            S_FETCH: begin
               if (branch_taken) begin
                  if (imem_ready) begin
                     pc_q <= tgt_aligned;
                  end else begin
                     state_q <= S_DROP;
                     tgt_q   <= tgt_aligned;
                  end
               end else if (imem_ready && slot_free) begin
                  pc_q <= pc_inc;
               end else if (valid_d && stall_d) begin
                  state_q <= S_HOLD;
                  req_q   <= 1'b0;
               end
            end
            S_HOLD: begin
               if (branch_taken) begin
                  pc_q    <= tgt_aligned;
                  state_q <= S_FETCH;
                  req_q   <= 1'b1;
               end else if (!stall_d) begin
                  state_q <= S_FETCH;
                  req_q   <= 1'b1;
               end
            end
            S_DROP: begin
               if (branch_taken) tgt_q <= tgt_aligned;
               if (imem_ready) begin
                  pc_q    <= branch_taken ? tgt_aligned : tgt_q;
                  state_q <= S_FETCH;
               end
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;

   if_id_reg #(.N(N)) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .load_i  (capture),
      .flush_i (branch_taken),
      .stall_i (stall_d),
      .instr_i (imem_rdata),
      .pc_i    (pc_q),
      .instr_o (instr_d),
      .pc_o    (pc_d),
      .valid_o (valid_d)
   );

`ifdef FETCH_PERF_EN
   localparam int unsigned PERF_W = 32;

   logic [PERF_W-1:0] perf_fetched_q;
   logic [PERF_W-1:0] perf_stall_q;

   // Saturating counters: captures and stalled-live cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (capture && (perf_fetched_q != '1))
            perf_fetched_q <= perf_fetched_q + PERF_W'(1);
         if (valid_d && stall_d && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + PERF_W'(1);
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus redirect/reset/perf sequences.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall_d;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [31:0] instr_d;
   logic [63:0] pc_d;
   logic        valid_d;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int n_vec = 0;
   int n_err = 0;

   fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall_d       (stall_d),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .valid_d       (valid_d)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_stall    (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [31:0] rdata;
      logic        stall;
      logic        br;
      logic [63:0] tgt;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_valid;
      logic        chk_data;
      logic [31:0] e_instr;
      logic [63:0] e_pc;
      logic [10:0] e_opc;
   } vec_t;

   vec_t tbl [13];

   function automatic vec_t mk(input logic rst, rdy, input logic [31:0] rdata,
                               input logic stall, br, input logic [63:0] tgt,
                               input logic e_req, input logic [63:0] e_addr,
                               input logic e_valid, chk_data, input logic [31:0] e_instr,
                               input logic [63:0] e_pc, input logic [10:0] e_opc);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stall = stall; v.br = br; v.tgt = tgt;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.chk_data = chk_data;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_opc = e_opc;
      return v;
   endfunction

   task automatic drive(input logic r, rdy, input logic [31:0] rd,
                        input logic st, br, input logic [63:0] tgt);
      reset = r; imem_ready = rdy; imem_rdata = rd;
      stall_d = st; branch_taken = br; branch_target = tgt;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      n_vec++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_if(input string nm, input logic e_req, input logic [63:0] e_addr,
                         input logic e_valid);
      chk({nm, ".req"},   64'(imem_req),  64'(e_req));
      chk({nm, ".addr"},  imem_addr,      e_addr);
      chk({nm, ".valid"}, 64'(valid_d),   64'(e_valid));
   endtask

   initial begin
      //           rst rdy rdata          st br tgt                     req addr                   vld chk instr          pc                     opc
      tbl[0]  = mk(1, 0, 32'h0,          0, 0, 64'h0,                  0, 64'h0,                  0, 1, 32'h0,          64'h0,                 11'h000);
      tbl[1]  = mk(0, 0, 32'h0,          0, 0, 64'h0,                  1, 64'h0,                  0, 1, 32'h0,          64'h0,                 11'h000);
      tbl[2]  = mk(0, 1, 32'hF8400000,   0, 0, 64'h0,                  1, 64'h4,                  1, 1, 32'hF8400000,   64'h0,                 11'h7C2);
      tbl[3]  = mk(0, 1, 32'hF8000000,   0, 0, 64'h0,                  1, 64'h8,                  1, 1, 32'hF8000000,   64'h4,                 11'h7C0);
      tbl[4]  = mk(0, 1, 32'h8B000000,   0, 0, 64'h0,                  1, 64'hC,                  1, 1, 32'h8B000000,   64'h8,                 11'h458);
      tbl[5]  = mk(0, 0, 32'h0,          1, 0, 64'h0,                  0, 64'hC,                  1, 1, 32'h8B000000,   64'h8,                 11'h458);
      tbl[6]  = mk(0, 0, 32'h0,          1, 0, 64'h0,                  0, 64'hC,                  1, 1, 32'h8B000000,   64'h8,                 11'h458);
      tbl[7]  = mk(0, 0, 32'h0,          1, 0, 64'h0,                  0, 64'hC,                  1, 1, 32'h8B000000,   64'h8,                 11'h458);
      tbl[8]  = mk(0, 0, 32'h0,          0, 0, 64'h0,                  1, 64'hC,                  0, 0, 32'h0,          64'h0,                 11'h000);
      tbl[9]  = mk(0, 1, 32'h91000000,   0, 0, 64'h0,                  1, 64'h10,                 1, 1, 32'h91000000,   64'hC,                 11'h488);
      tbl[10] = mk(0, 1, 32'h12345678,   0, 1, 64'hFFFFFFFFFFFFFFFF,   1, 64'hFFFFFFFFFFFFFFFC,   0, 0, 32'h0,          64'h0,                 11'h000);
      tbl[11] = mk(0, 1, 32'hD65F03C0,   0, 0, 64'h0,                  1, 64'h0,                  1, 1, 32'hD65F03C0,   64'hFFFFFFFFFFFFFFFC,  11'h6B2);
      tbl[12] = mk(0, 0, 32'h0,          0, 0, 64'h0,                  1, 64'h0,                  0, 0, 32'h0,          64'h0,                 11'h000);

      drive(1, 0, 32'h0, 0, 0, 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].rst, tbl[i].rdy, tbl[i].rdata, tbl[i].stall, tbl[i].br, tbl[i].tgt);
         tick();
         chk_if($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid);
         if (tbl[i].chk_data) begin
            chk($sformatf("vec%0d.instr", i), 64'(instr_d), 64'(tbl[i].e_instr));
            chk($sformatf("vec%0d.pc_d", i),  pc_d,         tbl[i].e_pc);
            chk($sformatf("vec%0d.opc", i),   64'(opcode_of(instr_d)), 64'(tbl[i].e_opc));
         end
      end

      // Redirect to 0x103 during a two-cycle wait: stale word dropped, refetch at 0x100.
      drive(1, 0, 32'h0, 0, 0, 64'h0);      tick();
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick(); chk_if("drop.start", 1, 64'h0, 0);
      drive(0, 0, 32'h0, 0, 1, 64'h103);    tick(); chk_if("drop.br",    1, 64'h0, 0);
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick(); chk_if("drop.wait",  1, 64'h0, 0);
      drive(0, 1, 32'hDEADBEEF, 0, 0, 64'h0); tick(); chk_if("drop.late", 1, 64'h100, 0);
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick(); chk_if("drop.new",   1, 64'h100, 0);
      drive(0, 1, 32'h8B020020, 0, 0, 64'h0); tick(); chk_if("drop.cap", 1, 64'h104, 1);
      chk("drop.instr", 64'(instr_d), 64'h8B020020);
      chk("drop.pc_d",  pc_d,         64'h100);

      // Redirect coinciding with ready and a stalled live slot.
      drive(0, 1, 32'hAAAA0000, 1, 1, 64'h200); tick(); chk_if("brst", 1, 64'h200, 0);

      // Reset while a request is pending; stray ready afterwards must not capture.
      drive(0, 1, 32'h8B010000, 0, 0, 64'h0); tick(); chk_if("rst.cap", 1, 64'h204, 1);
      chk("rst.cap.pc_d", pc_d, 64'h200);
      drive(1, 0, 32'h0, 0, 0, 64'h0);      tick(); chk_if("rst.mid", 0, 64'h0, 0);
      chk("rst.mid.instr", 64'(instr_d), 64'h0);
      chk("rst.mid.pc_d",  pc_d,         64'h0);
      drive(0, 1, 32'hFFFFFFFF, 0, 0, 64'h0); tick(); chk_if("rst.stray", 1, 64'h0, 0);
      chk("rst.stray.instr", 64'(instr_d), 64'h0);
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick(); chk_if("rst.after", 1, 64'h0, 0);

`ifdef FETCH_PERF_EN
      drive(1, 0, 32'h0, 0, 0, 64'h0);      tick();
      chk("perf.rst.fetched", 64'(perf_fetched), 64'h0);
      chk("perf.rst.stall",   64'(perf_stall),   64'h0);
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 32'hF8400000 + 32'(k), 0, 0, 64'h0);
         tick();
      end
      drive(0, 0, 32'h0, 1, 0, 64'h0);      tick();
      drive(0, 0, 32'h0, 1, 0, 64'h0);      tick();
      drive(0, 0, 32'h0, 0, 0, 64'h0);      tick();
      chk("perf.fetched", 64'(perf_fetched), 64'd5);
      chk("perf.stall",   64'(perf_stall),   64'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
